i2c_reg_ctrl: RTL and testbench

Register-access controller that sits directly downstream of the I2C slave in the USB port controller. It consumes the byte-level events the slave produces (address match, received bytes, read requests, STOP) and turns them into register-file operations. It tracks the register pointer with auto-increment and serves read bytes back to the slave. A write to the R_TRANSMIT register (0x50) raises a one-cycle transmit command toward the protocol layer.

---
 rtl/i2c_reg_ctrl.sv | 81 ++++++++
 tb/tb_i2c_reg_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_ctrl.sv
// Register-access controller behind the I2C slave: turns byte-level bus events
// into register-file reads/writes with an auto-incrementing pointer.
module i2c_reg_ctrl #(
  parameter int         DEPTH         = 128,
  parameter logic [7:0] TRANSMIT_ADDR = 8'h50
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       AddrMatch,
  input  logic       RW,
  input  logic       RxValid,
  input  logic [7:0] RxData,
  input  logic       RdReq,
  input  logic       StopDet,
  output logic [7:0] TxData,
  output logic       TxValid,
  output logic       TransmitPulse,
  output logic [7:0] TransmitCmd,
  output logic       Busy,
  output logic [7:0] Pointer
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_L = 9'(DEPTH);

  typedef enum logic [1:0] {IDLE, WADDR, WDATA, READ} state_t;

  state_t          state;
  logic [7:0]      regs [DEPTH];
  logic            in_range;
  logic [AW-1:0]   idx;

  assign in_range = ({1'b0, Pointer} < DEPTH_L);
  assign idx      = Pointer[AW-1:0];
  assign Busy     = (state != IDLE);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state         <= IDLE;
      Pointer       <= 8'h00;
      TxData        <= 8'h00;
      TxValid       <= 1'b0;
      TransmitPulse <= 1'b0;
      TransmitCmd   <= 8'h00;
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
    end else begin
      TxValid       <= 1'b0;
      TransmitPulse <= 1'b0;
      if (AddrMatch) begin
        // (Repeated) START outranks STOP and any data event in the same cycle.
        state <= RW ? READ : WADDR;
      end else begin
        if (RdReq) begin
          TxValid <= 1'b1;
          if (state == READ) begin
            TxData  <= in_range ? regs[idx] : 8'h00;
            Pointer <= Pointer + 8'd1;
          end else begin
            TxData <= 8'hFF;
          end
        end
        if (RxValid) begin
          if (state == WADDR) begin
            Pointer <= RxData;
            state   <= WDATA;
          end else if (state == WDATA) begin
            if (in_range) regs[idx] <= RxData;
            if (Pointer == TRANSMIT_ADDR) begin
              TransmitCmd   <= RxData;
              TransmitPulse <= 1'b1;
            end
            Pointer <= Pointer + 8'd1;
          end
        end
        // Placed last so STOP overrides the WADDR->WDATA move after the byte is handled.
        if (StopDet && state != IDLE) state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Table-driven directed bench for i2c_reg_ctrl plus a hand-written reset-mid-burst sequence.
module tb_i2c_reg_ctrl;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       AddrMatch, RW, RxValid, RdReq, StopDet;
  logic [7:0] RxData;
  logic [7:0] TxData, TransmitCmd, Pointer;
  logic       TxValid, TransmitPulse, Busy;

  int checks = 0;
  int errors = 0;

  i2c_reg_ctrl #(.DEPTH(128), .TRANSMIT_ADDR(8'h50)) dut (
    .CLK(CLK), .Reset(Reset), .AddrMatch(AddrMatch), .RW(RW),
    .RxValid(RxValid), .RxData(RxData), .RdReq(RdReq), .StopDet(StopDet),
    .TxData(TxData), .TxValid(TxValid), .TransmitPulse(TransmitPulse),
    .TransmitCmd(TransmitCmd), .Busy(Busy), .Pointer(Pointer)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       am, rw, rxv;
    logic [7:0] rxd;
    logic       rd, stop;
    logic       txv;
    logic [7:0] txd;
    logic       tp;
    logic [7:0] tc;
    logic       busy;
    logic [7:0] ptr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic am, logic rw, logic rxv, logic [7:0] rxd, logic rd,
                              logic stop, logic txv, logic [7:0] txd, logic tp,
                              logic [7:0] tc, logic busy, logic [7:0] ptr);
    vec_t v;
    v.am = am; v.rw = rw; v.rxv = rxv; v.rxd = rxd; v.rd = rd; v.stop = stop;
    v.txv = txv; v.txd = txd; v.tp = tp; v.tc = tc; v.busy = busy; v.ptr = ptr;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(input vec_t v, input int idx);
    chk("TxValid",       idx, {7'd0, TxValid},       {7'd0, v.txv});
    chk("TxData",        idx, TxData,                v.txd);
    chk("TransmitPulse", idx, {7'd0, TransmitPulse}, {7'd0, v.tp});
    chk("TransmitCmd",   idx, TransmitCmd,           v.tc);
    chk("Busy",          idx, {7'd0, Busy},          {7'd0, v.busy});
    chk("Pointer",       idx, Pointer,               v.ptr);
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge CLK);
    AddrMatch = v.am; RW = v.rw; RxValid = v.rxv; RxData = v.rxd;
    RdReq = v.rd; StopDet = v.stop;
    @(posedge CLK);
    #1;
    check_outs(v, idx);
    AddrMatch = 0; RW = 0; RxValid = 0; RxData = 8'h00; RdReq = 0; StopDet = 0;
  endtask

  initial begin
    vec_t rv;
    Reset = 0; AddrMatch = 0; RW = 0; RxValid = 0; RxData = 0; RdReq = 0; StopDet = 0;

    //      am rw rxv rxd   rd st | txv txd   tp tc    bsy ptr
    // reset release, idle
    tbl.push_back(mk(0,0,0,8'h00,0,0, 0,8'h00,0,8'h00,0,8'h00));
    tbl.push_back(mk(0,0,0,8'h00,0,0, 0,8'h00,0,8'h00,0,8'h00));
    // write 0x01 to R_TRANSMIT
    tbl.push_back(mk(1,0,0,8'h00,0,0, 0,8'h00,0,8'h00,1,8'h00));
    tbl.push_back(mk(0,0,1,8'h50,0,0, 0,8'h00,0,8'h00,1,8'h50));
    tbl.push_back(mk(0,0,1,8'h01,0,0, 0,8'h00,1,8'h01,1,8'h51));
    tbl.push_back(mk(0,0,0,8'h00,0,1, 0,8'h00,0,8'h01,0,8'h51));
    // read back 0x50
    tbl.push_back(mk(1,0,0,8'h00,0,0, 0,8'h00,0,8'h01,1,8'h51));
    tbl.push_back(mk(0,0,1,8'h50,0,0, 0,8'h00,0,8'h01,1,8'h50));
    tbl.push_back(mk(1,1,0,8'h00,0,0, 0,8'h00,0,8'h01,1,8'h50));
    tbl.push_back(mk(0,0,0,8'h00,1,0, 1,8'h01,0,8'h01,1,8'h51));
    tbl.push_back(mk(0,0,0,8'h00,0,1, 0,8'h01,0,8'h01,0,8'h51));
    // burst write A1 B2 C3 at 0x10, repeated START, read back
    tbl.push_back(mk(1,0,0,8'h00,0,0, 0,8'h01,0,8'h01,1,8'h51));
    tbl.push_back(mk(0,0,1,8'h10,0,0, 0,8'h01,0,8'h01,1,8'h10));
    tbl.push_back(mk(0,0,1,8'hA1,0,0, 0,8'h01,0,8'h01,1,8'h11));
    tbl.push_back(mk(0,0,1,8'hB2,0,0, 0,8'h01,0,8'h01,1,8'h12));
    tbl.push_back(mk(0,0,1,8'hC3,0,0, 0,8'h01,0,8'h01,1,8'h13));
    tbl.push_back(mk(1,0,0,8'h00,0,0, 0,8'h01,0,8'h01,1,8'h13));
    tbl.push_back(mk(0,0,1,8'h10,0,0, 0,8'h01,0,8'h01,1,8'h10));
    tbl.push_back(mk(1,1,0,8'h00,0,0, 0,8'h01,0,8'h01,1,8'h10));
    tbl.push_back(mk(0,0,0,8'h00,1,0, 1,8'hA1,0,8'h01,1,8'h11));
    tbl.push_back(mk(0,0,0,8'h00,1,0, 1,8'hB2,0,8'h01,1,8'h12));
    tbl.push_back(mk(0,0,0,8'h00,1,0, 1,8'hC3,0,8'h01,1,8'h13));
    tbl.push_back(mk(0,0,0,8'h00,0,1, 0,8'hC3,0,8'h01,0,8'h13));
    // out-of-range write at 0x7F/0x80, read at 0xFF wraps pointer
    tbl.push_back(mk(1,0,0,8'h00,0,0, 0,8'hC3,0,8'h01,1,8'h13));
    tbl.push_back(mk(0,0,1,8'h7F,0,0, 0,8'hC3,0,8'h01,1,8'h7F));
    tbl.push_back(mk(0,0,1,8'h11,0,0, 0,8'hC3,0,8'h01,1,8'h80));
    tbl.push_back(mk(0,0,1,8'h22,0,0, 0,8'hC3,0,8'h01,1,8'h81));
    tbl.push_back(mk(1,0,0,8'h00,0,0, 0,8'hC3,0,8'h01,1,8'h81));
    tbl.push_back(mk(0,0,1,8'hFF,0,0, 0,8'hC3,0,8'h01,1,8'hFF));
    tbl.push_back(mk(1,1,0,8'h00,0,0, 0,8'hC3,0,8'h01,1,8'hFF));
    tbl.push_back(mk(0,0,0,8'h00,1,0, 1,8'h00,0,8'h01,1,8'h00));
    tbl.push_back(mk(0,0,0,8'h00,1,0, 1,8'h00,0,8'h01,1,8'h01));
    tbl.push_back(mk(1,0,0,8'h00,0,0, 0,8'h00,0,8'h01,1,8'h01));
    tbl.push_back(mk(0,0,1,8'h7F,0,0, 0,8'h00,0,8'h01,1,8'h7F));
    tbl.push_back(mk(1,1,0,8'h00,0,0, 0,8'h00,0,8'h01,1,8'h7F));
    tbl.push_back(mk(0,0,0,8'h00,1,0, 1,8'h11,0,8'h01,1,8'h80));
    tbl.push_back(mk(0,0,0,8'h00,1,0, 1,8'h00,0,8'h01,1,8'h81));
    tbl.push_back(mk(0,0,0,8'h00,0,1, 0,8'h00,0,8'h01,0,8'h81));
    // RdReq and RxValid while IDLE
    tbl.push_back(mk(0,0,0,8'h00,1,0, 1,8'hFF,0,8'h01,0,8'h81));
    tbl.push_back(mk(0,0,0,8'h00,0,0, 0,8'hFF,0,8'h01,0,8'h81));
    tbl.push_back(mk(0,0,1,8'h33,0,0, 0,8'hFF,0,8'h01,0,8'h81));
    // RxValid + StopDet together, then verify the byte landed
    tbl.push_back(mk(1,0,0,8'h00,0,0, 0,8'hFF,0,8'h01,1,8'h81));
    tbl.push_back(mk(0,0,1,8'h20,0,0, 0,8'hFF,0,8'h01,1,8'h20));
    tbl.push_back(mk(0,0,1,8'h5A,0,1, 0,8'hFF,0,8'h01,0,8'h21));
    tbl.push_back(mk(1,0,0,8'h00,0,0, 0,8'hFF,0,8'h01,1,8'h21));
    tbl.push_back(mk(0,0,1,8'h20,0,0, 0,8'hFF,0,8'h01,1,8'h20));
    tbl.push_back(mk(1,1,0,8'h00,0,0, 0,8'hFF,0,8'h01,1,8'h20));
    tbl.push_back(mk(0,0,0,8'h00,1,0, 1,8'h5A,0,8'h01,1,8'h21));
    // AddrMatch + StopDet (AddrMatch wins), AddrMatch + RdReq (read ignored)
    tbl.push_back(mk(1,1,0,8'h00,0,1, 0,8'h5A,0,8'h01,1,8'h21));
    tbl.push_back(mk(0,0,0,8'h00,1,0, 1,8'h00,0,8'h01,1,8'h22));
    tbl.push_back(mk(1,1,0,8'h00,1,0, 0,8'h00,0,8'h01,1,8'h22));
    // RdReq + StopDet: byte served, then IDLE
    tbl.push_back(mk(1,0,0,8'h00,0,0, 0,8'h00,0,8'h01,1,8'h22));
    tbl.push_back(mk(0,0,1,8'h10,0,0, 0,8'h00,0,8'h01,1,8'h10));
    tbl.push_back(mk(1,1,0,8'h00,0,0, 0,8'h00,0,8'h01,1,8'h10));
    tbl.push_back(mk(0,0,0,8'h00,1,1, 1,8'hA1,0,8'h01,0,8'h11));
    tbl.push_back(mk(0,0,0,8'h00,0,0, 0,8'hA1,0,8'h01,0,8'h11));
    // second R_TRANSMIT write: one-cycle pulse, command held afterwards
    tbl.push_back(mk(1,0,0,8'h00,0,0, 0,8'hA1,0,8'h01,1,8'h11));
    tbl.push_back(mk(0,0,1,8'h50,0,0, 0,8'hA1,0,8'h01,1,8'h50));
    tbl.push_back(mk(0,0,1,8'h7E,0,0, 0,8'hA1,1,8'h7E,1,8'h51));
    tbl.push_back(mk(0,0,1,8'h99,0,0, 0,8'hA1,0,8'h7E,1,8'h52));
    tbl.push_back(mk(0,0,0,8'h00,0,1, 0,8'hA1,0,8'h7E,0,8'h52));

    // reset state before release
    repeat (2) @(posedge CLK);
    #1;
    check_outs(mk(0,0,0,8'h00,0,0, 0,8'h00,0,8'h00,0,8'h00), -1);
    @(negedge CLK);
    Reset = 1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // reset mid-burst: two bytes into WDATA
    apply(mk(1,0,0,8'h00,0,0, 0,8'hA1,0,8'h7E,1,8'h52), 100);
    apply(mk(0,0,1,8'h40,0,0, 0,8'hA1,0,8'h7E,1,8'h40), 101);
    apply(mk(0,0,1,8'h01,0,0, 0,8'hA1,0,8'h7E,1,8'h41), 102);
    apply(mk(0,0,1,8'h02,0,0, 0,8'hA1,0,8'h7E,1,8'h42), 103);
    @(negedge CLK);
    Reset = 0;
    #1;
    check_outs(mk(0,0,0,8'h00,0,0, 0,8'h00,0,8'h00,0,8'h00), 104);
    @(negedge CLK);
    Reset = 1;
    apply(mk(0,0,1,8'h55,0,0, 0,8'h00,0,8'h00,0,8'h00), 105);
    apply(mk(1,0,0,8'h00,0,0, 0,8'h00,0,8'h00,1,8'h00), 106);
    apply(mk(0,0,1,8'h40,0,0, 0,8'h00,0,8'h00,1,8'h40), 107);
    apply(mk(1,1,0,8'h00,0,0, 0,8'h00,0,8'h00,1,8'h40), 108);
    rv = mk(0,0,0,8'h00,1,0, 1,8'h00,0,8'h00,1,8'h41);
    apply(rv, 109);
    apply(mk(0,0,0,8'h00,1,0, 1,8'h00,0,8'h00,1,8'h42), 110);
    apply(mk(1,0,0,8'h00,0,0, 0,8'h00,0,8'h00,1,8'h42), 111);
    apply(mk(0,0,1,8'h10,0,0, 0,8'h00,0,8'h00,1,8'h10), 112);
    apply(mk(1,1,0,8'h00,0,0, 0,8'h00,0,8'h00,1,8'h10), 113);
    apply(mk(0,0,0,8'h00,1,0, 1,8'h00,0,8'h00,1,8'h11), 114);
    apply(mk(0,0,0,8'h00,0,1, 0,8'h00,0,8'h00,0,8'h11), 115);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
